// File: rtl/sm_divider_seq.sv
// sm_divider_seq
// ---------------------------------------------------------------------------
// Multi-cycle restoring divider for signed-magnitude operands.
// Bit WIDTH-1 of each operand is the sign. Bits WIDTH-2:0 are the magnitude,
// giving M = WIDTH-1 magnitude bits. The divider resolves one quotient bit per
// clock, MSB first. A full division takes M clocks in CALC, followed by one
// DONE cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   numerator    signed-magnitude dividend, captured on an accepted start
//   denominator  signed-magnitude divisor, captured on an accepted start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse when the results are valid
//   quotient     signed-magnitude quotient, held until the next result
//   remainder    signed-magnitude remainder (takes the sign of the numerator)
//   divbyzero    divisor magnitude was zero, held with the results
//   zero         remainder magnitude is zero, held with the results
// ---------------------------------------------------------------------------
module sm_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divbyzero,
  output logic             zero
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered state
  state_t           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [M-1:0]     dvd_q,     dvd_d;     // dividend shifts out, quotient bits shift in
  logic [M-1:0]     dvs_q,     dvs_d;     // divisor magnitude
  logic [M-1:0]     prem_q,    prem_d;    // partial remainder (always < divisor)
  logic             qsign_q,   qsign_d;
  logic             rsign_q,   rsign_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] quot_q,    quot_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic             dbz_q,     dbz_d;
  logic             zero_q,    zero_d;

  // Iteration datapath
  logic [M:0]       prem_shift;   // M+1-bit partial remainder after shifting in the next bit
  logic             q_bit;
  logic [M-1:0]     prem_sub;
  logic [M-1:0]     prem_next;
  logic [M-1:0]     dvd_next;

  // One restoring step.
  // The stored partial remainder is always below the divisor, so it fits in
  // M bits. Only the shifted value needs the extra bit. When the subtraction
  // is taken, the true difference is below the divisor, so its low M bits are
  // exact.
  always_comb begin
    prem_shift = {prem_q, dvd_q[M-1]};
    q_bit      = (prem_shift >= {1'b0, dvs_q});
    prem_sub   = prem_shift[M-1:0] - dvs_q;
    if (q_bit) begin
      prem_next = prem_sub;
    end else begin
      prem_next = prem_shift[M-1:0];
    end
    dvd_next = {dvd_q[M-2:0], q_bit};
  end

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = numerator[M-1:0];
          dvs_d   = denominator[M-1:0];
          qsign_d = numerator[M] ^ denominator[M];
          rsign_d = numerator[M];
          prem_d  = {M{1'b0}};
          cnt_d   = {CW{1'b0}};
          if (denominator[M-1:0] == {M{1'b0}}) begin
            // Zero divisor of either sign: report immediately, no iteration
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = {WIDTH{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            dbz_d   = 1'b1;
            zero_d  = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_CALC: begin
        prem_d = prem_next;
        dvd_d  = dvd_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Last quotient bit resolved this edge.
          // A zero magnitude never carries a sign.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = {qsign_q & (|dvd_next), dvd_next};
          rem_d   = {rsign_q & (|prem_next), prem_next};
          dbz_d   = 1'b0;
          zero_d  = ~(|prem_next);
        end else begin
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      dvd_q   <= {M{1'b0}};
      dvs_q   <= {M{1'b0}};
      prem_q  <= {M{1'b0}};
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign divbyzero = dbz_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sm_divider_seq.sv
// Directed bench for sm_divider_seq.
// The WIDTH=8 instance gets hand-computed vectors. WIDTH=3 is swept
// exhaustively and WIDTH=16 uses random pairs, both against a small
// signed-magnitude model.
module tb_sm_divider_seq;

  logic clk;
  logic rst_n;

  logic        start8, busy8, done8, dbz8, z8;
  logic [7:0]  num8, den8, q8, r8;
  logic        start3, busy3, done3, dbz3, z3;
  logic [2:0]  num3, den3, q3, r3;
  logic        start16, busy16, done16, dbz16, z16;
  logic [15:0] num16, den16, q16, r16;

  int n_cmp;
  int n_fail;

  sm_divider_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .numerator(num8), .denominator(den8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .divbyzero(dbz8), .zero(z8)
  );

  sm_divider_seq #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .numerator(num3), .denominator(den3),
    .busy(busy3), .done(done3), .quotient(q3), .remainder(r3), .divbyzero(dbz3), .zero(z3)
  );

  sm_divider_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .numerator(num16), .denominator(den16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .divbyzero(dbz16), .zero(z16)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: observed=no done expected=done within bound", tag);
  endtask

  // Reference signed-magnitude divide for width w
  function automatic void model(input int w, input logic [31:0] n, input logic [31:0] d,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz, output logic z);
    logic [31:0] mask, nm, dm, qm, rm, sbit;
    logic ns, ds;
    mask = (32'd1 << (w - 1)) - 32'd1;
    sbit = 32'd1 << (w - 1);
    nm = n & mask;
    dm = d & mask;
    ns = n[w-1];
    ds = d[w-1];
    if (dm == 32'd0) begin
      q = 32'd0; r = 32'd0; dbz = 1'b1; z = 1'b1;
    end else begin
      qm  = nm / dm;
      rm  = nm % dm;
      q   = qm | (((ns ^ ds) && (qm != 32'd0)) ? sbit : 32'd0);
      r   = rm | ((ns && (rm != 32'd0)) ? sbit : 32'd0);
      dbz = 1'b0;
      z   = (rm == 32'd0);
    end
  endfunction

  // One WIDTH=8 operation with a single-cycle start pulse.
  // lat counts edges after the accepting edge until done is visible.
  task automatic op8(input logic [7:0] n, input logic [7:0] d, output int lat, output int nbusy);
    @(negedge clk);
    start8 = 1'b1; num8 = n; den8 = d;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      if (done8) break;
      if (busy8) nbusy++;
      if (lat >= 40) begin
        timeout_fail("op8_timeout");
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  // One operation on the WIDTH=3 or WIDTH=16 instance, checked against the model
  task automatic op_sweep(input int w, input logic [31:0] n, input logic [31:0] d);
    logic [31:0] eq, er;
    logic edbz, ez;
    int lat;
    model(w, n, d, eq, er, edbz, ez);
    @(negedge clk);
    if (w == 3) begin
      start3 = 1'b1; num3 = n[2:0]; den3 = d[2:0];
    end else begin
      start16 = 1'b1; num16 = n[15:0]; den16 = d[15:0];
    end
    @(posedge clk);
    #1 start3 = 1'b0; start16 = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if ((w == 3) ? done3 : done16) break;
      if (lat >= 40) begin
        timeout_fail($sformatf("w%0d_timeout n=%0h d=%0h", w, n, d));
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (w == 3) begin
      check($sformatf("w3_q n=%0h d=%0h", n, d), {29'd0, q3}, eq);
      check($sformatf("w3_r n=%0h d=%0h", n, d), {29'd0, r3}, er);
      check($sformatf("w3_dbz n=%0h d=%0h", n, d), {31'd0, dbz3}, {31'd0, edbz});
      check($sformatf("w3_zero n=%0h d=%0h", n, d), {31'd0, z3}, {31'd0, ez});
    end else begin
      check($sformatf("w16_q n=%0h d=%0h", n, d), {16'd0, q16}, eq);
      check($sformatf("w16_r n=%0h d=%0h", n, d), {16'd0, r16}, er);
      check($sformatf("w16_dbz n=%0h d=%0h", n, d), {31'd0, dbz16}, {31'd0, edbz});
      check($sformatf("w16_zero n=%0h d=%0h", n, d), {31'd0, z16}, {31'd0, ez});
    end
  endtask

  logic [7:0] bn [0:23];
  logic [7:0] bd [0:23];

  initial begin
    int lat, nbusy, bad;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start8 = 1'b0; num8 = 8'h00; den8 = 8'h00;
    start3 = 1'b0; num3 = 3'd0; den3 = 3'd0;
    start16 = 1'b0; num16 = 16'h0; den16 = 16'h0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_q", {24'd0, q8}, 32'd0);
    check("rst_r", {24'd0, r8}, 32'd0);
    check("rst_dbz_zero", {30'd0, dbz8, z8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // +100 / +7
    op8(8'h64, 8'h07, lat, nbusy);
    check("t1_latency", lat, 32'd7);
    check("t1_busy_cycles", nbusy, 32'd7);
    check("t1_busy_at_done", {31'd0, busy8}, 32'd0);
    check("t1_q", {24'd0, q8}, 32'h0E);
    check("t1_r", {24'd0, r8}, 32'h02);
    check("t1_flags", {30'd0, dbz8, z8}, 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done8}, 32'd0);
    num8 = 8'h11; den8 = 8'h00;
    repeat (3) @(negedge clk);
    check("t1_hold_q", {24'd0, q8}, 32'h0E);
    check("t1_hold_r", {24'd0, r8}, 32'h02);

    // Sign handling
    op8(8'hE4, 8'h07, lat, nbusy);
    check("t2a_q", {24'd0, q8}, 32'h8E);
    check("t2a_r", {24'd0, r8}, 32'h82);
    op8(8'h64, 8'h87, lat, nbusy);
    check("t2b_q", {24'd0, q8}, 32'h8E);
    check("t2b_r", {24'd0, r8}, 32'h02);

    // Exact division: remainder sign forced positive
    op8(8'h8E, 8'h07, lat, nbusy);
    check("t3a_q", {24'd0, q8}, 32'h82);
    check("t3a_r", {24'd0, r8}, 32'h00);
    check("t3a_flags", {30'd0, dbz8, z8}, 32'd1);

    // Divide by -0
    op8(8'h05, 8'h80, lat, nbusy);
    check("t3b_latency", lat, 32'd0);
    check("t3b_busy_cycles", nbusy, 32'd0);
    check("t3b_busy", {31'd0, busy8}, 32'd0);
    check("t3b_flags", {30'd0, dbz8, z8}, 32'd3);
    check("t3b_q", {24'd0, q8}, 32'd0);
    check("t3b_r", {24'd0, r8}, 32'd0);

    // Numerator smaller than divisor
    op8(8'h03, 8'h7F, lat, nbusy);
    check("t4_q", {24'd0, q8}, 32'h00);
    check("t4_r", {24'd0, r8}, 32'h03);
    check("t4_flags", {30'd0, dbz8, z8}, 32'd0);

    // Back-to-back with start held high.
    // Only vectors 0, 8 and 16 should be accepted. The rest would be
    // divide-by-zero if taken.
    for (int k = 0; k < 24; k++) begin
      bn[k] = 8'h05;
      bd[k] = 8'h80;
    end
    bn[0]  = 8'h64; bd[0]  = 8'h07;
    bn[8]  = 8'h15; bd[8]  = 8'h04;
    bn[16] = 8'hE4; bd[16] = 8'h87;
    @(negedge clk);
    start8 = 1'b1; num8 = bn[0]; den8 = bd[0];
    bad = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if ((done8 !== ((k % 8) == 0)) || (busy8 !== ((k % 8) != 0))) bad++;
      if (k == 8) begin
        check("b2b_0_q", {24'd0, q8}, 32'h0E);
        check("b2b_0_r", {24'd0, r8}, 32'h02);
      end
      if (k == 16) begin
        check("b2b_8_q", {24'd0, q8}, 32'h05);
        check("b2b_8_r", {24'd0, r8}, 32'h01);
        check("b2b_8_dbz", {31'd0, dbz8}, 32'd0);
      end
      if (k == 24) begin
        check("b2b_16_q", {24'd0, q8}, 32'h0E);
        check("b2b_16_r", {24'd0, r8}, 32'h82);
        start8 = 1'b0;
      end else begin
        num8 = bn[k]; den8 = bd[k];
      end
    end
    check("b2b_done_busy_pattern", bad, 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the middle of CALC
    @(negedge clk);
    start8 = 1'b1; num8 = 8'h64; den8 = 8'h07;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy8}, 32'd0);
    check("mid_rst_done", {31'd0, done8}, 32'd0);
    check("mid_rst_q", {24'd0, q8}, 32'd0);
    check("mid_rst_r", {24'd0, r8}, 32'd0);
    check("mid_rst_flags", {30'd0, dbz8, z8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((done8 !== 1'b0) || (busy8 !== 1'b0)) bad++;
    end
    check("post_rst_no_stale", bad, 32'd0);
    op8(8'h09, 8'h02, lat, nbusy);
    check("post_rst_q", {24'd0, q8}, 32'h04);
    check("post_rst_r", {24'd0, r8}, 32'h01);
    check("post_rst_latency", lat, 32'd7);

    // WIDTH=3 exhaustive
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        op_sweep(3, n, d);
      end
    end

    // WIDTH=16 directed corners, then random pairs
    op_sweep(16, 32'h0005, 32'h0001);
    op_sweep(16, 32'h8005, 32'h0001);
    op_sweep(16, 32'h0003, 32'h0009);
    op_sweep(16, 32'hFFFF, 32'h7FFF);
    op_sweep(16, 32'h7FFF, 32'h8001);
    op_sweep(16, 32'h8000, 32'h0003);
    for (int i = 0; i < 1500; i++) begin
      op_sweep(16, {16'd0, 16'($urandom)}, {16'd0, 16'($urandom)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
